// File: rtl/osnt_rx_meta_builder.sv
// Store-and-forward RX stage: buffers whole packets, then emits them with length/timestamp metadata in tuser.
// Optional: define OSNT_RX_STAMP_CLEAR_EN to zero tdata[63:0] on each packet's first output beat.
module osnt_rx_meta_builder #(
  parameter int         AXI_DATA_WIDTH = 512,
  parameter int         AXI_USER_WIDTH = 128,
  parameter int         DATA_DEPTH     = 512,
  parameter int         META_DEPTH     = 32,
  parameter int         MAX_PKT_BEATS  = 160,
  parameter logic [7:0] SRC_PORT       = 8'h01
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [AXI_DATA_WIDTH-1:0]   i_tdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_tkeep,
  input  logic                        i_tvalid,
  input  logic                        i_tlast,
  output logic                        i_tready,
  output logic [AXI_DATA_WIDTH-1:0]   o_tdata,
  output logic [AXI_DATA_WIDTH/8-1:0] o_tkeep,
  output logic [AXI_USER_WIDTH-1:0]   o_tuser,
  output logic                        o_tvalid,
  output logic                        o_tlast,
  input  logic                        o_tready,
  output logic [31:0]                 pkt_count,
  output logic [31:0]                 trunc_count
);

  localparam int KW  = AXI_DATA_WIDTH / 8;
  localparam int DW  = AXI_DATA_WIDTH + KW + 1;
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int MAW = $clog2(META_DEPTH);
  localparam int MW  = 81;

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  function automatic logic [15:0] popcount(input logic [KW-1:0] k);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < KW; i++) c = c + 16'(k[i]);
    return c;
  endfunction

  state_t          state_q, state_d;
  logic [63:0]     ts_q, ts_d;
  logic [15:0]     len_q, len_d;
  logic [15:0]     beats_q, beats_d;
  logic            commit_q, commit_d;
  logic [MW-1:0]   mword_q, mword_d;
  logic            dwr_en;
  logic            dwr_last;
  logic [15:0]     pc;
  logic            accept;
  logic            consume;

  logic [DW-1:0]   data_mem [DATA_DEPTH];
  logic [DAW:0]    dwr_q, drd_q;
  logic            data_full;
  logic [DW-1:0]   rd_word;

  logic [MW-1:0]   meta_mem [META_DEPTH];
  logic [MAW:0]    mwr_q, mrd_q;
  logic [MAW:0]    meta_used;
  logic            meta_empty;
  logic            meta_full;
  logic [MW-1:0]   meta_word;
  logic            first_q;

  assign data_full  = (dwr_q[DAW] != drd_q[DAW]) && (dwr_q[DAW-1:0] == drd_q[DAW-1:0]);
  assign meta_used  = mwr_q - mrd_q;
  assign meta_empty = (mwr_q == mrd_q);
  // The commit lands a cycle after the last beat, so a pending commit already owns a meta slot.
  assign meta_full  = ({1'b0, meta_used} + {{(MAW+1){1'b0}}, commit_q}) >= (MAW+2)'(META_DEPTH);

  assign i_tready = !reset && ((state_q == DROP) || (!data_full && !meta_full));
  assign accept   = i_tvalid && i_tready;
  assign pc       = popcount(i_tkeep);

  always_comb begin
    state_d  = state_q;
    ts_d     = ts_q;
    len_d    = len_q;
    beats_d  = beats_q;
    commit_d = 1'b0;
    mword_d  = mword_q;
    dwr_en   = 1'b0;
    dwr_last = i_tlast;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ts_d    = i_tdata[63:0];
          len_d   = pc;
          beats_d = 16'd1;
          dwr_en  = 1'b1;
          if (i_tlast) begin
            commit_d = 1'b1;
            mword_d  = {1'b0, i_tdata[63:0], pc};
          end else begin
            state_d = PKT;
          end
        end
      end
      PKT: begin
        if (accept) begin
          len_d   = len_q + pc;
          beats_d = beats_q + 16'd1;
          dwr_en  = 1'b1;
          if (i_tlast) begin
            commit_d = 1'b1;
            mword_d  = {1'b0, ts_q, len_q + pc};
            state_d  = IDLE;
          end else if ((beats_q + 16'd1) == 16'(MAX_PKT_BEATS)) begin
            dwr_last = 1'b1;
            commit_d = 1'b1;
            mword_d  = {1'b1, ts_q, len_q + pc};
            state_d  = DROP;
          end
        end
      end
      DROP: begin
        if (accept && i_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ts_q     <= '0;
      len_q    <= '0;
      beats_q  <= '0;
      commit_q <= 1'b0;
      mword_q  <= '0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      len_q    <= len_d;
      beats_q  <= beats_d;
      commit_q <= commit_d;
      mword_q  <= mword_d;
    end
  end

  always_ff @(posedge clk) begin
    if (dwr_en) data_mem[dwr_q[DAW-1:0]] <= {dwr_last, i_tkeep, i_tdata};
    if (commit_q) meta_mem[mwr_q[MAW-1:0]] <= mword_q;
  end

  assign rd_word   = data_mem[drd_q[DAW-1:0]];
  assign meta_word = meta_mem[mrd_q[MAW-1:0]];

  // Data is only presented once its packet's metadata exists.
  assign o_tvalid = !reset && !meta_empty;
  assign o_tlast  = rd_word[DW-1];
  assign o_tkeep  = rd_word[DW-2 -: KW];
  assign consume  = o_tvalid && o_tready;

  always_comb begin
    o_tdata = rd_word[AXI_DATA_WIDTH-1:0];
`ifdef OSNT_RX_STAMP_CLEAR_EN
    if (first_q) o_tdata[63:0] = '0;
`else
`endif
  end

  always_comb begin
    o_tuser = '0;
    if (first_q) begin
      o_tuser[15:0]  = meta_word[15:0];
      o_tuser[23:16] = SRC_PORT;
      o_tuser[95:32] = meta_word[79:16];
      o_tuser[96]    = meta_word[80];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dwr_q       <= '0;
      drd_q       <= '0;
      mwr_q       <= '0;
      mrd_q       <= '0;
      first_q     <= 1'b1;
      pkt_count   <= '0;
      trunc_count <= '0;
    end else begin
      if (dwr_en) dwr_q <= dwr_q + (DAW+1)'(1);
      if (commit_q) begin
        mwr_q <= mwr_q + (MAW+1)'(1);
        if (mword_q[80]) trunc_count <= trunc_count + 32'd1;
      end
      if (consume) begin
        drd_q <= drd_q + (DAW+1)'(1);
        if (o_tlast) begin
          mrd_q     <= mrd_q + (MAW+1)'(1);
          first_q   <= 1'b1;
          pkt_count <= pkt_count + 32'd1;
        end else begin
          first_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_osnt_rx_meta_builder.sv
// Scoreboard testbench for osnt_rx_meta_builder (DATA_DEPTH=16, MAX_PKT_BEATS=4).
module tb_osnt_rx_meta_builder;

  localparam int MAXB = 4;
  localparam logic [7:0] SRC = 8'h01;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
    logic [127:0] u;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] i_tdata = '0;
  logic [63:0]  i_tkeep = '0;
  logic         i_tvalid = 1'b0;
  logic         i_tlast = 1'b0;
  logic         i_tready;
  logic [511:0] o_tdata;
  logic [63:0]  o_tkeep;
  logic [127:0] o_tuser;
  logic         o_tvalid;
  logic         o_tlast;
  logic         o_tready = 1'b0;
  logic [31:0]  pkt_count;
  logic [31:0]  trunc_count;

  beat_t sb[$];
  beat_t mon_e;
  int checks = 0;
  int errors = 0;
  int exp_pkts = 0;
  int exp_trunc = 0;
  int cyc = 0;

  osnt_rx_meta_builder #(
    .DATA_DEPTH(16),
    .MAX_PKT_BEATS(MAXB)
  ) dut (
    .clk(clk), .reset(reset),
    .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tvalid(i_tvalid), .i_tlast(i_tlast), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tuser(o_tuser), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
    .o_tready(o_tready), .pkt_count(pkt_count), .trunc_count(trunc_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Output scoreboard: every consumed beat is checked against the next expected beat.
  always @(negedge clk) begin
    if (!reset && o_tvalid && o_tready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got d0=%h last=%b, required no output", o_tdata[63:0], o_tlast);
      end else begin
        mon_e = sb.pop_front();
        if (o_tdata !== mon_e.d || o_tkeep !== mon_e.k || o_tlast !== mon_e.l || o_tuser !== mon_e.u) begin
          errors++;
          $display("FAIL out_beat: got d0=%h keep=%h last=%b user=%h, required d0=%h keep=%h last=%b user=%h",
                   o_tdata[63:0], o_tkeep, o_tlast, o_tuser, mon_e.d[63:0], mon_e.k, mon_e.l, mon_e.u);
        end else if (o_tdata[511:64] !== mon_e.d[511:64]) begin
          errors++;
          $display("FAIL out_data_hi: got %h, required %h", o_tdata[127:64], mon_e.d[127:64]);
        end
      end
    end
  end

  function automatic logic [63:0] keep_of(input int bytes);
    logic [63:0] ones;
    ones = '1;
    return ones >> (64 - bytes);
  endfunction

  // Drives one packet; expected output beats are pushed once the last stored beat is accepted.
  task automatic send_pkt(input int n, input int last_bytes, input logic [63:0] ts,
                          input int wait_max, output bit ok);
    logic [511:0] in_d[$];
    logic [63:0]  in_k[$];
    logic [511:0] d;
    bit           trunc;
    int           nout;
    int           len;
    bit           acc;
    beat_t        e;
    trunc = (n > MAXB);
    nout  = trunc ? MAXB : n;
    len   = 0;
    ok    = 1'b1;
    for (int b = 0; b < n; b++) begin
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
      if (b == 0) d[63:0] = ts;
      in_d.push_back(d);
      in_k.push_back((b == n - 1) ? keep_of(last_bytes) : keep_of(64));
      if (b < nout) len += (b == n - 1) ? last_bytes : 64;
    end
    for (int b = 0; b < n; b++) begin
      i_tdata  = in_d[b];
      i_tkeep  = in_k[b];
      i_tlast  = (b == n - 1);
      i_tvalid = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < wait_max && !acc; c++) begin
        @(negedge clk);
        acc = i_tready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        ok = 1'b0;
        i_tvalid = 1'b0;
        return;
      end
      if (b == nout - 1) begin
        for (int j = 0; j < nout; j++) begin
          e.d = in_d[j];
          e.k = in_k[j];
          e.l = (j == nout - 1);
          e.u = '0;
          if (j == 0) begin
            e.u = {31'b0, trunc, ts, 8'h00, SRC, 16'(len)};
`ifdef OSNT_RX_STAMP_CLEAR_EN
            e.d[63:0] = '0;
`endif
          end
          sb.push_back(e);
        end
        exp_pkts++;
        if (trunc) exp_trunc++;
      end
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic wait_drain(output int left);
    int c;
    c = 0;
    o_tready = 1'b1;
    while ((sb.size() != 0 || o_tvalid) && c < 500) begin
      @(posedge clk);
      #1;
      c++;
    end
    left = sb.size() + (o_tvalid ? 1 : 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (i_tready !== 1'b0 || o_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got i_tready=%b o_tvalid=%b, required 0 0", i_tready, o_tvalid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (o_tvalid !== 1'b0 || pkt_count !== 32'd0 || trunc_count !== 32'd0 || i_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got o_tvalid=%b pkt=%0d trunc=%0d i_tready=%b, required 0 0 0 1",
               o_tvalid, pkt_count, trunc_count, i_tready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit ok;
    int left;
    o_tready = 1'b1;
    send_pkt(1, 64, 64'h1122334455667788, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_accept: got no accept, required accept"); end
    wait_drain(left);
    checks++;
    if (left != 0 || pkt_count !== 32'd1) begin
      errors++;
      $display("FAIL single_count: got left=%0d pkt=%0d, required 0 1", left, pkt_count);
    end
  endtask

  task automatic test_multi_beat();
    bit ok;
    int left;
    send_pkt(3, 22, 64'hA5A5_0000_DEAD_BEEF, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL multi_accept: got no accept, required accept"); end
    wait_drain(left);
    checks++;
    if (left != 0 || pkt_count !== 32'(exp_pkts)) begin
      errors++;
      $display("FAIL multi_count: got left=%0d pkt=%0d, required 0 %0d", left, pkt_count, exp_pkts);
    end
  endtask

  task automatic test_latency();
    bit ok;
    int left;
    send_pkt(1, 10, 64'h0000_0000_0000_0042, 20, ok);
    @(negedge clk);
    checks++;
    if (o_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got o_tvalid=%b one cycle after tlast, required 0", o_tvalid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (o_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL latency_due: got o_tvalid=%b two cycles after tlast, required 1", o_tvalid);
    end
    wait_drain(left);
  endtask

  task automatic test_backpressure();
    bit ok;
    int acc_cnt;
    int left;
    o_tready = 1'b0;
    acc_cnt = 0;
    ok = 1'b1;
    while (ok && acc_cnt < 40) begin
      send_pkt(1, 1 + int'($urandom_range(63)), {32'hB0B0_0000, 32'(acc_cnt)}, 6, ok);
      if (ok) acc_cnt++;
    end
    checks++;
    if (acc_cnt != 16) begin
      errors++;
      $display("FAIL bp_fill: got %0d packets accepted, required 16", acc_cnt);
    end
    @(negedge clk);
    checks++;
    if (i_tready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready: got i_tready=%b when full, required 0", i_tready);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (o_tvalid !== 1'b1 || o_tdata !== sb[0].d || o_tuser !== sb[0].u) begin
        errors++;
        $display("FAIL bp_hold: got valid=%b d0=%h user=%h, required 1 %h %h",
                 o_tvalid, o_tdata[63:0], o_tuser, sb[0].d[63:0], sb[0].u);
      end
    end
    @(posedge clk); #1;
    wait_drain(left);
    checks++;
    if (left != 0 || pkt_count !== 32'(exp_pkts)) begin
      errors++;
      $display("FAIL bp_drain: got left=%0d pkt=%0d, required 0 %0d", left, pkt_count, exp_pkts);
    end
  endtask

  task automatic test_truncate();
    bit ok1;
    bit ok2;
    int left;
    o_tready = 1'b1;
    send_pkt(6, 64, 64'hFEED_FACE_0BAD_F00D, 20, ok1);
    send_pkt(1, 33, 64'h0123_4567_89AB_CDEF, 20, ok2);
    checks++;
    if (!ok1 || !ok2) begin
      errors++;
      $display("FAIL trunc_accept: got ok=%b%b, required 11", ok1, ok2);
    end
    wait_drain(left);
    checks++;
    if (left != 0 || trunc_count !== 32'd1 || pkt_count !== 32'(exp_pkts)) begin
      errors++;
      $display("FAIL trunc_count: got left=%0d trunc=%0d pkt=%0d, required 0 1 %0d",
               left, trunc_count, pkt_count, exp_pkts);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit all_ok;
    int t0;
    int left;
    o_tready = 1'b1;
    all_ok = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      send_pkt(1, 64, 64'(i) + 64'h7000, 20, ok);
      all_ok &= ok;
    end
    checks++;
    if (!all_ok || (cyc - t0) != 5) begin
      errors++;
      $display("FAIL b2b_rate: got %0d cycles for 5 single-beat packets, required 5", cyc - t0);
    end
    for (int i = 0; i < 8; i++) begin
      send_pkt(1 + (i % 5), 1 + int'($urandom_range(63)), {32'hC0DE, 32'(i)}, 20, ok);
      all_ok &= ok;
    end
    wait_drain(left);
    checks++;
    if (!all_ok || left != 0 || pkt_count !== 32'(exp_pkts) || trunc_count !== 32'(exp_trunc)) begin
      errors++;
      $display("FAIL b2b_counts: got left=%0d pkt=%0d trunc=%0d, required 0 %0d %0d",
               left, pkt_count, trunc_count, exp_pkts, exp_trunc);
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    int left;
    o_tready = 1'b0;
    send_pkt(1, 64, 64'h1, 20, ok);
    send_pkt(2, 5, 64'h2, 20, ok);
    i_tkeep  = '1;
    i_tlast  = 1'b0;
    i_tvalid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (o_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_buffered: got o_tvalid=%b, required 1", o_tvalid);
    end
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    reset = 1'b1;
    sb.delete();
    exp_pkts  = 0;
    exp_trunc = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (o_tvalid !== 1'b0 || pkt_count !== 32'd0 || trunc_count !== 32'd0) begin
      errors++;
      $display("FAIL midrst_state: got o_tvalid=%b pkt=%0d trunc=%0d, required 0 0 0",
               o_tvalid, pkt_count, trunc_count);
    end
    @(posedge clk); #1;
    o_tready = 1'b1;
    send_pkt(2, 40, 64'h5555_AAAA_5555_AAAA, 20, ok);
    wait_drain(left);
    checks++;
    if (!ok || left != 0 || pkt_count !== 32'd1) begin
      errors++;
      $display("FAIL midrst_after: got ok=%b left=%0d pkt=%0d, required 1 0 1", ok, left, pkt_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_beat();
    test_latency();
    test_backpressure();
    test_truncate();
    test_back_to_back();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
